lcd_controller: RTL
===================

# lcd_controller

Sequencer that owns the character-LCD pins (LCD_DATA, LCD_RS, LCD_RW, LCD_EN) in the memory-mapped I/O region. It runs the HD44780-style power-up initialisation on its own, then accepts one command or data byte at a time from the data-memory I/O decode through a valid/ready handshake. For each byte it generates the setup, enable-pulse, hold and execution-wait timing, so software no longer bit-bangs LCD_EN through the control register.

## Interface
- SETUP_CYC, 2: cycles RS/DATA are stable before EN rises.
- EN_HIGH_CYC, 12: EN high width in cycles.
- HOLD_CYC, 2: cycles RS/DATA are held after EN falls.
- CMD_WAIT_CYC, 2000: execution wait after a normal command or data byte.
- CLEAR_WAIT_CYC, 82000: execution wait after clear/home commands.
- POWERUP_CYC, 750000: wait after reset before the first init command.
- All parameters are in the range 1..2^20-1. The internal counter is 20 bits wide.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_rs  in  1  0 = command, 1 = data (character).
- req_data  in  8  byte to send.
- req_ready  out  1  controller can accept a request this cycle.
- busy  out  1  init or a transaction is in progress (= !req_ready).
- init_done  out  1  power-up init sequence has completed; sticky until reset.
- LCD_DATA  out  8  LCD data bus.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  read/write; always 0 (write-only).
- LCD_EN  out  1  enable strobe.

## Operation
- States:
  - PWRUP: wait POWERUP_CYC cycles.
  - INIT: load init ROM entry idx.
  - IDLE
  - SETUP
  - PULSE
  - HOLD
  - WAIT
- Init ROM (RS=0): 0x38, 0x0C, 0x01, 0x06. idx counts 0..3.
- Reset (async, rst=0) immediately forces all outputs to their reset values:
  - LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0
  - req_ready=0, busy=1, init_done=0
  - state=PWRUP, counter=0, idx=0
- PWRUP -> INIT after POWERUP_CYC cycles.
- INIT: latch ROM[idx] with RS=0, then go to SETUP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches req_rs and req_data into LCD_RS and LCD_DATA, then goes to SETUP.
- SETUP: EN=0 for SETUP_CYC cycles, then PULSE.
- PULSE: EN=1 for EN_HIGH_CYC cycles, then HOLD.
- HOLD: EN=0 for HOLD_CYC cycles, then WAIT.
- WAIT length:
  - CLEAR_WAIT_CYC if the latched RS=0 and the latched byte is 0x01, 0x02 or 0x03.
  - CMD_WAIT_CYC otherwise.
- Leaving WAIT:
  - During init with idx<3: idx++, go to INIT.
  - During init with idx=3: set init_done=1, go to IDLE.
  - Otherwise go to IDLE.
- LCD_DATA and LCD_RS keep their latched values from handshake until the next handshake, including through IDLE.
- Requests are not buffered. req_valid while req_ready=0 is ignored, and the requester must hold it.
- A reset mid-transaction aborts immediately: EN drops asynchronously and the init sequence restarts.

## Timing
- Handshake in cycle N:
  - LCD_RS/LCD_DATA are updated at the edge ending N.
  - req_ready=0 from cycle N+1.
- LCD_EN goes high at cycle N+1+SETUP_CYC and stays high for exactly EN_HIGH_CYC cycles.
- req_ready returns to 1 at cycle N+1+SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+WAIT.
- Back-to-back transfers: the next handshake is possible in that same cycle, with zero idle bubble.
- Per-byte latency = SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+WAIT cycles.
- init_done and req_ready rise on the same edge.
- All outputs are registered, with no combinational path from req_* to the LCD pins.

## Test plan
Parameters for all scenarios: SETUP=2, EN_HIGH=4, HOLD=2, CMD_WAIT=10, CLEAR_WAIT=40, POWERUP=20.

- Reset release:
  - Stimulus: release reset and hold req_valid=0.
  - Response: after POWERUP, four EN pulses carry DATA 0x38, 0x0C, 0x01, 0x06 with RS=0, each pulse 4 cycles wide.
  - init_done and req_ready rise exactly 20+18+18+48+18=122 cycles after reset release.
- Data write after init:
  - Stimulus: req_rs=1, req_data=0x41.
  - Response: RS=1 and DATA=0x41 next cycle, EN high on cycles +3..+6, req_ready back after 18 cycles, LCD_RW=0 throughout.
- Clear command:
  - Stimulus: req_rs=0, req_data=0x01.
  - Response: req_ready low for 48 cycles.
  - Repeat with req_rs=1, req_data=0x01: wait is only 18 cycles.
- Back-to-back traffic:
  - Stimulus: hold req_valid=1 with bytes 0x48, 0x49.
  - Response: second handshake occurs in the cycle req_ready returns.
  - A req_valid pulse during busy is never latched, and DATA is unchanged.
- Reset mid-pulse:
  - Stimulus: assert rst while EN=1.
  - Response: EN, DATA and RS go to 0 without waiting for a clock edge, init_done=0, and the full init sequence is replayed after release.

Source files
------------

// File: rtl/lcd_controller.sv
// lcd_controller: HD44780-style character LCD write sequencer.
// Runs the power-up init on its own, then sends one command or data
// byte per valid/ready handshake with setup, EN pulse, hold and wait.
// Ports:
//   clk, rst (async, active-low)
//   req_valid, req_rs, req_data[7:0] : request in
//   req_ready, busy, init_done       : status out
//   LCD_DATA[7:0], LCD_RS, LCD_RW, LCD_EN : LCD pins (all registered)
module lcd_controller #(
   parameter int SETUP_CYC      = 2,
   parameter int EN_HIGH_CYC    = 12,
   parameter int HOLD_CYC       = 2,
   parameter int CMD_WAIT_CYC   = 2000,
   parameter int CLEAR_WAIT_CYC = 82000,
   parameter int POWERUP_CYC    = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       busy,
   output logic       init_done,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN
);

   localparam logic [2:0] S_PWRUP = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_PULSE = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   // Terminal counts: a phase of length L occupies counts 0..L-1.
   localparam logic [19:0] L_PWR   = 20'(POWERUP_CYC - 1);
   localparam logic [19:0] L_SETUP = 20'(SETUP_CYC - 1);
   localparam logic [19:0] L_PULSE = 20'(EN_HIGH_CYC - 1);
   localparam logic [19:0] L_HOLD  = 20'(HOLD_CYC - 1);
   localparam logic [19:0] L_CMD   = 20'(CMD_WAIT_CYC - 1);
   localparam logic [19:0] L_CLR   = 20'(CLEAR_WAIT_CYC - 1);

   logic [2:0]  r_state;
   logic [19:0] r_cnt;
   logic [1:0]  r_idx;
   logic        r_ready;
   logic        r_init_done;
   logic        r_en;
   logic        r_rs;
   logic [7:0]  r_data;

   logic        w_clear;
   logic [19:0] w_wait_last;
   logic [1:0]  w_idx_nxt;

   function automatic logic [7:0] init_rom(input logic [1:0] i);
      unique case (i)
         2'd0:    init_rom = 8'h38;
         2'd1:    init_rom = 8'h0C;
         2'd2:    init_rom = 8'h01;
         default: init_rom = 8'h06;
      endcase
   endfunction

   // Clear display and return home need the long execution wait.
   assign w_clear     = !r_rs &&
                        (r_data == 8'h01 || r_data == 8'h02 ||
                         r_data == 8'h03);
   assign w_wait_last = w_clear ? L_CLR : L_CMD;
   assign w_idx_nxt   = r_idx + 2'd1;

   // Loading an init ROM entry happens on the edge that leaves PWRUP
   // or WAIT, so the next byte's SETUP follows with no extra cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_PWRUP;
         r_cnt       <= 20'd0;
         r_idx       <= 2'd0;
         r_ready     <= 1'b0;
         r_init_done <= 1'b0;
         r_en        <= 1'b0;
         r_rs        <= 1'b0;
         r_data      <= 8'h00;
      end else begin
         r_cnt <= r_cnt + 20'd1;
         unique case (r_state)
            S_PWRUP: begin
               if (r_cnt == L_PWR) begin
                  r_cnt   <= 20'd0;
                  r_idx   <= 2'd0;
                  r_rs    <= 1'b0;
                  r_data  <= init_rom(2'd0);
                  r_state <= S_SETUP;
               end
            end
            S_IDLE: begin
               r_cnt <= 20'd0;
               if (req_valid) begin
                  r_rs    <= req_rs;
                  r_data  <= req_data;
                  r_ready <= 1'b0;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == L_SETUP) begin
                  r_cnt   <= 20'd0;
                  r_en    <= 1'b1;
                  r_state <= S_PULSE;
               end
            end
            S_PULSE: begin
               if (r_cnt == L_PULSE) begin
                  r_cnt   <= 20'd0;
                  r_en    <= 1'b0;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (r_cnt == L_HOLD) begin
                  r_cnt   <= 20'd0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == w_wait_last) begin
                  r_cnt <= 20'd0;
                  if (!r_init_done && r_idx != 2'd3) begin
                     r_idx   <= w_idx_nxt;
                     r_rs    <= 1'b0;
                     r_data  <= init_rom(w_idx_nxt);
                     r_state <= S_SETUP;
                  end else begin
                     r_init_done <= 1'b1;
                     r_ready     <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end
            end
            default: begin
               r_cnt   <= 20'd0;
               r_en    <= 1'b0;
               r_state <= S_PWRUP;
            end
         endcase
      end
   end

   assign req_ready = r_ready;
   assign busy      = ~r_ready;
   assign init_done = r_init_done;
   assign LCD_DATA  = r_data;
   assign LCD_RS    = r_rs;
   assign LCD_RW    = 1'b0;
   assign LCD_EN    = r_en;

endmodule
